// File: rtl/coin_pkg.sv
// Shared coin/keypad definitions for the vending-machine coin entry front end.
// Holds coin values, display glyph codes, keypad codes and the balance helper.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_5   = 2'd0,
    COIN_10  = 2'd1,
    COIN_25  = 2'd2,
    COIN_100 = 2'd3
  } coin_e;

  localparam logic [9:0] COIN_SYM_BASE = 10'd20;
  localparam logic [9:0] PURCHASE_SYM  = 10'd19;

  localparam logic [3:0] KEY_COIN_FIRST = 4'd1;
  localparam logic [3:0] KEY_COIN_LAST  = 4'd4;
  localparam logic [3:0] KEY_A          = 4'd10;
  localparam logic [3:0] KEY_B          = 4'd11;
  localparam logic [3:0] KEY_C          = 4'd12;
  localparam logic [3:0] KEY_D          = 4'd13;

  function automatic logic [6:0] coin_value(input coin_e c);
    logic [6:0] v;
    case (c)
      COIN_5:   v = 7'd5;
      COIN_10:  v = 7'd10;
      COIN_25:  v = 7'd25;
      default:  v = 7'd100;
    endcase
    return v;
  endfunction

  function automatic logic [9:0] coin_glyph(input coin_e c);
    return COIN_SYM_BASE + {8'd0, c};
  endfunction

  // Adds a coin to the balance, clamping at the display limit.
  function automatic logic [10:0] sat_add(input logic [10:0] a, input logic [6:0] b,
                                          input logic [10:0] lim);
    logic [11:0] sum;
    sum = {1'b0, a} + {5'd0, b};
    return (sum > {1'b0, lim}) ? lim : sum[10:0];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw push button and emits a single pulse per accepted press.
// A press is a 0 sample followed by STABLE_SAMPLES consecutive 1 samples.
module button_debounce #(
  parameter int STABLE_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_sample_tick,
  input  logic i_pulse_tick,
  output logic o_press
);

  localparam int HW = STABLE_SAMPLES + 1;
  localparam logic [HW-1:0] PRESS_PATTERN = {1'b0, {STABLE_SAMPLES{1'b1}}};

  logic [1:0]    r_sync;
  logic [HW-1:0] r_hist;

  // NOTE: the history resets to all zeros, so a button still held when reset
  // releases is seen as a fresh press once it has been sampled stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      // NOTE: non-blocking keeps the two sync stages as two real flops.
      r_sync <= {r_sync[0], i_btn};
      if (i_sample_tick) begin
        r_hist <= {r_hist[HW-2:0], r_sync[1]};
      end
    end
  end

  // History only moves on the sample tick, so the pattern is stable at the
  // following pulse tick and the match fires exactly once per press.
  assign o_press = i_pulse_tick && (r_hist == PRESS_PATTERN);

endmodule

// File: rtl/coin_entry_frontend.sv
// Vending-machine front end: tick dividers, button debouncers and the
// coin-select / balance manager feeding the item and display logic.
module coin_entry_frontend
  import coin_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_HZ = 100,
  parameter int SEGMENT_HZ  = 1000,
  parameter int BAL_MAX     = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        money_mode,
  input  logic        purchase_mode,
  input  logic [3:0]  key_value,
  input  logic        key_press,
  input  logic [9:0]  stock_a,
  input  logic [9:0]  stock_b,
  input  logic [9:0]  stock_c,
  input  logic [9:0]  stock_d,
  input  logic [9:0]  price_a,
  input  logic [9:0]  price_b,
  input  logic [9:0]  price_c,
  input  logic [9:0]  price_d,
  output logic        segment_tick,
  output logic        cycle_pulse,
  output logic        side_dir,
  output logic        key_or_select,
  output logic [9:0]  coin_symbol,
  output logic [10:0] total_value,
  output logic        vend_pulse,
  output logic [1:0]  vend_item
);

  localparam int DEB_DIV = CLK_HZ / DEBOUNCE_HZ;
  localparam int SEG_DIV = CLK_HZ / SEGMENT_HZ;
  localparam int DEB_CW  = $clog2(DEB_DIV + 1);
  localparam int SEG_CW  = $clog2(SEG_DIV + 1);
  localparam logic [DEB_CW-1:0] DEB_LAST = DEB_CW'(DEB_DIV - 1);
  localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(SEG_DIV - 1);
  localparam logic [10:0]       BAL_LIM  = 11'(BAL_MAX);

  logic [DEB_CW-1:0] r_deb_cnt;
  logic [SEG_CW-1:0] r_seg_cnt;
  logic              r_delayed_tick;
  logic              w_debounce_tick;
  logic              w_delayed_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt      <= '0;
      r_seg_cnt      <= '0;
      r_delayed_tick <= 1'b0;
    end else begin
      r_deb_cnt      <= (r_deb_cnt == DEB_LAST) ? '0 : r_deb_cnt + 1'b1;
      r_seg_cnt      <= (r_seg_cnt == SEG_LAST) ? '0 : r_seg_cnt + 1'b1;
      r_delayed_tick <= w_debounce_tick;
    end
  end

  assign w_debounce_tick = (r_deb_cnt == DEB_LAST);
  assign w_delayed_tick  = r_delayed_tick;
  assign segment_tick    = (r_seg_cnt == SEG_LAST);

  logic w_left_pulse;
  logic w_right_pulse;
  logic w_sel_pulse;

  button_debounce #(.STABLE_SAMPLES(2)) u_db_left (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_left),
    .i_sample_tick(w_debounce_tick), .i_pulse_tick(w_delayed_tick), .o_press(w_left_pulse)
  );

  button_debounce #(.STABLE_SAMPLES(2)) u_db_right (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_right),
    .i_sample_tick(w_debounce_tick), .i_pulse_tick(w_delayed_tick), .o_press(w_right_pulse)
  );

  button_debounce #(.STABLE_SAMPLES(2)) u_db_select (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_select),
    .i_sample_tick(w_debounce_tick), .i_pulse_tick(w_delayed_tick), .o_press(w_sel_pulse)
  );

  assign cycle_pulse = w_left_pulse | w_right_pulse;

  // Keypad decode: keys 1..4 map to coins 0..3, keys A..D to items 0..3.
  logic       w_key_is_coin;
  logic       w_key_is_item;
  coin_e      w_key_coin;
  logic [1:0] w_key_item;
  logic [9:0] w_stock;
  logic [9:0] w_price;

  assign w_key_is_coin = (key_value >= KEY_COIN_FIRST) && (key_value <= KEY_COIN_LAST);
  assign w_key_is_item = (key_value >= KEY_A) && (key_value <= KEY_D);
  assign w_key_coin    = coin_e'(2'(key_value - KEY_COIN_FIRST));
  assign w_key_item    = 2'(key_value - KEY_A);

  always_comb begin
    w_stock = stock_a;
    w_price = price_a;
    case (w_key_item)
      2'd1:    begin w_stock = stock_b; w_price = price_b; end
      2'd2:    begin w_stock = stock_c; w_price = price_c; end
      2'd3:    begin w_stock = stock_d; w_price = price_d; end
      default: ;
    endcase
  end

  coin_e       r_coin;
  logic [10:0] r_total;
  logic        r_vend_pulse;
  logic [1:0]  r_vend_item;
  logic        r_side_dir;
  logic        r_key_or_select;

  coin_e       w_coin_next;
  logic [10:0] w_total_next;
  logic        w_vend_next;
  logic [1:0]  w_item_next;
  logic        w_side_next;
  logic        w_kos_next;
  logic [1:0]  w_idx_up;
  logic [1:0]  w_idx_dn;

  assign w_idx_up = r_coin + 2'd1;
  assign w_idx_dn = r_coin - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coin          <= COIN_5;
      r_total         <= '0;
      r_vend_pulse    <= 1'b0;
      r_vend_item     <= '0;
      r_side_dir      <= 1'b0;
      r_key_or_select <= 1'b0;
    end else begin
      r_coin          <= w_coin_next;
      r_total         <= w_total_next;
      r_vend_pulse    <= w_vend_next;
      r_vend_item     <= w_item_next;
      r_side_dir      <= w_side_next;
      r_key_or_select <= w_kos_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_coin_next  = r_coin;
    w_total_next = r_total;
    w_vend_next  = 1'b0;
    w_item_next  = r_vend_item;
    w_side_next  = r_side_dir;
    w_kos_next   = r_key_or_select;

    if (w_right_pulse)     w_side_next = 1'b1;
    else if (w_left_pulse) w_side_next = 1'b0;

    if (w_sel_pulse)    w_kos_next = 1'b1;
    else if (key_press) w_kos_next = 1'b0;

    if (money_mode) begin
      if (w_right_pulse)     w_coin_next = coin_e'(w_idx_up);
      else if (w_left_pulse) w_coin_next = coin_e'(w_idx_dn);

      // Select credits the coin shown before any same-cycle side change.
      if (w_sel_pulse)
        w_total_next = sat_add(r_total, coin_value(r_coin), BAL_LIM);
      else if (key_press && w_key_is_coin)
        w_total_next = sat_add(r_total, coin_value(w_key_coin), BAL_LIM);
    end else if (purchase_mode) begin
      if (w_sel_pulse) begin
        w_total_next = '0;
      end else if (key_press && w_key_is_item) begin
        if ((w_stock != '0) && (r_total >= {1'b0, w_price})) begin
          w_total_next = r_total - {1'b0, w_price};
          w_vend_next  = 1'b1;
          w_item_next  = w_key_item;
        end
      end
    end
  end

  assign side_dir      = r_side_dir;
  assign key_or_select = r_key_or_select;
  assign coin_symbol   = coin_glyph(r_coin);
  assign total_value   = r_total;
  assign vend_pulse    = r_vend_pulse;
  assign vend_item     = r_vend_item;

endmodule

// File: tb/tb_coin_entry_frontend.sv
// Directed bench for coin_entry_frontend with a shortened divider
// (10-cycle debounce tick, 4-cycle segment tick).
module tb_coin_entry_frontend;

  localparam int DEB_DIV = 10;
  localparam int SEG_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_select = 1'b0;
  logic        money_mode = 1'b0, purchase_mode = 1'b0;
  logic [3:0]  key_value = '0;
  logic        key_press = 1'b0;
  logic [9:0]  stock_a = '0, stock_b = '0, stock_c = '0, stock_d = '0;
  logic [9:0]  price_a = '0, price_b = '0, price_c = '0, price_d = '0;
  logic        segment_tick, cycle_pulse, side_dir, key_or_select;
  logic [9:0]  coin_symbol;
  logic [10:0] total_value;
  logic        vend_pulse;
  logic [1:0]  vend_item;

  coin_entry_frontend #(
    .CLK_HZ(1000), .DEBOUNCE_HZ(100), .SEGMENT_HZ(250), .BAL_MAX(999)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_select(btn_select),
    .money_mode(money_mode), .purchase_mode(purchase_mode),
    .key_value(key_value), .key_press(key_press),
    .stock_a(stock_a), .stock_b(stock_b), .stock_c(stock_c), .stock_d(stock_d),
    .price_a(price_a), .price_b(price_b), .price_c(price_c), .price_d(price_d),
    .segment_tick(segment_tick), .cycle_pulse(cycle_pulse), .side_dir(side_dir),
    .key_or_select(key_or_select), .coin_symbol(coin_symbol), .total_value(total_value),
    .vend_pulse(vend_pulse), .vend_item(vend_item)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cycle_pulse = 0;
  int n_sel_pulse = 0;

  always @(negedge clk) begin
    if (cycle_pulse)     n_cycle_pulse <= n_cycle_pulse + 1;
    if (dut.w_sel_pulse) n_sel_pulse   <= n_sel_pulse + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_deb_tick();
    int k = 0;
    @(negedge clk);
    while (!dut.w_debounce_tick && k < 5 * DEB_DIV) begin
      @(negedge clk);
      k++;
    end
    if (!dut.w_debounce_tick) check("deb_tick_timeout", 0, 1);
  endtask

  task automatic set_btns(input int id, input logic v);
    case (id)
      0:       btn_left = v;
      1:       btn_right = v;
      2:       btn_select = v;
      default: begin btn_left = v; btn_right = v; end
    endcase
  endtask

  task automatic press(input int id, input int hold_ticks);
    @(negedge clk);
    set_btns(id, 1'b1);
    repeat (hold_ticks * DEB_DIV) @(negedge clk);
    set_btns(id, 1'b0);
    repeat (3 * DEB_DIV) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] v, output logic vp, output logic [1:0] vi);
    @(negedge clk);
    key_value = v;
    key_press = 1'b1;
    @(negedge clk);
    key_press = 1'b0;
    vp = vend_pulse;
    vi = vend_item;
    @(negedge clk);
  endtask

  initial begin
    logic       vp;
    logic [1:0] vi;
    int         k;
    int         pulses_before;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_total", total_value, 0);
    check("rst_symbol", coin_symbol, 20);
    check("rst_side_dir", side_dir, 0);
    check("rst_key_or_select", key_or_select, 0);
    check("rst_vend_pulse", vend_pulse, 0);
    check("rst_cycle_pulse", cycle_pulse, 0);
    check("rst_segment_tick", segment_tick, 0);
    rst_n = 1'b1;

    // T1: divider periods and delayed tick lag
    wait_deb_tick();
    @(negedge clk);
    check("delayed_tick_lag", dut.w_delayed_tick, 1);
    check("deb_tick_width", dut.w_debounce_tick, 0);
    k = 1;
    while (!dut.w_debounce_tick && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("deb_tick_period", k, DEB_DIV);
    k = 0;
    while (!segment_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("seg_tick_width", segment_tick, 0);
    k = 1;
    while (!segment_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("seg_tick_period", k, SEG_DIV);

    // T2: one-sample glitch rejected; long hold gives one pulse (idle mode)
    wait_deb_tick();
    btn_select = 1'b1;
    repeat (DEB_DIV) @(negedge clk);
    btn_select = 1'b0;
    repeat (4 * DEB_DIV) @(negedge clk);
    check("glitch_sel_pulses", n_sel_pulse, 0);
    check("glitch_key_or_select", key_or_select, 0);
    press(2, 10);
    check("held_sel_pulses", n_sel_pulse, 1);
    check("held_key_or_select", key_or_select, 1);
    check("idle_total_held", total_value, 0);
    key(4'd3, vp, vi);
    check("key_clears_kos", key_or_select, 0);
    check("idle_key_ignored", total_value, 0);

    // T3: coin selection in money mode
    money_mode = 1'b1;
    press(1, 5);
    press(1, 5);
    check("right2_symbol", coin_symbol, 22);
    check("right_side_dir", side_dir, 1);
    check("right_cycle_pulses", n_cycle_pulse, 2);
    press(2, 5);
    check("select_25", total_value, 25);
    key(4'd5, vp, vi);
    check("key5_ignored", total_value, 25);
    press(0, 5);
    press(0, 5);
    check("left2_symbol", coin_symbol, 20);
    press(0, 5);
    check("left_wrap_symbol", coin_symbol, 23);
    check("left_side_dir", side_dir, 0);
    key(4'd2, vp, vi);
    check("key2_add10", total_value, 35);
    press(3, 5);
    check("both_one_pulse", n_cycle_pulse, 6);
    check("both_right_wins", side_dir, 1);
    check("both_wrap_symbol", coin_symbol, 20);

    // T4: saturation
    for (int i = 0; i < 9; i++) key(4'd4, vp, vi);
    check("nine_dollars", total_value, 935);
    key(4'd4, vp, vi);
    check("saturate_999", total_value, 999);
    key(4'd4, vp, vi);
    check("stay_999", total_value, 999);

    // T5: purchases
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rerst_total", total_value, 0);
    key(4'd4, vp, vi);
    key(4'd3, vp, vi);
    check("credit_125", total_value, 125);
    money_mode = 1'b0;
    purchase_mode = 1'b1;
    stock_b = 10'd3;
    price_b = 10'd100;
    key(4'd11, vp, vi);
    check("buy_b_pulse", vp, 1);
    check("buy_b_item", vi, 1);
    check("buy_b_total", total_value, 25);
    check("vend_pulse_one_cycle", vend_pulse, 0);
    stock_b = 10'd0;
    price_b = 10'd10;
    key(4'd11, vp, vi);
    check("no_stock_pulse", vp, 0);
    check("no_stock_total", total_value, 25);
    stock_c = 10'd5;
    price_c = 10'd50;
    key(4'd12, vp, vi);
    check("poor_pulse", vp, 0);
    check("poor_total", total_value, 25);
    key(4'd1, vp, vi);
    check("purchase_key1_ignored", total_value, 25);
    stock_d = 10'd1;
    price_d = 10'd25;
    key(4'd13, vp, vi);
    check("exact_d_pulse", vp, 1);
    check("exact_d_item", vi, 3);
    check("exact_d_total", total_value, 0);

    // T6: mode change keeps balance, refund, reset during hold
    purchase_mode = 1'b0;
    money_mode = 1'b1;
    key(4'd2, vp, vi);
    money_mode = 1'b0;
    purchase_mode = 1'b1;
    repeat (5) @(negedge clk);
    check("mode_change_keeps", total_value, 10);
    press(2, 5);
    check("refund_total", total_value, 0);
    purchase_mode = 1'b0;
    money_mode = 1'b1;
    key(4'd3, vp, vi);
    press(0, 5);
    press(1, 5);
    check("pre_rst_side_dir", side_dir, 1);
    check("pre_rst_total", total_value, 25);
    pulses_before = n_cycle_pulse;
    @(negedge clk);
    btn_left = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_total", total_value, 0);
    check("async_rst_side_dir", side_dir, 0);
    check("async_rst_symbol", coin_symbol, 20);
    check("async_rst_deb_cnt", dut.r_deb_cnt, 0);
    repeat (4 * DEB_DIV) @(negedge clk);
    check("in_rst_segment_tick", segment_tick, 0);
    btn_left = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * DEB_DIV) @(negedge clk);
    check("rst_hold_no_pulse", n_cycle_pulse, pulses_before);
    check("post_rst_side_dir", side_dir, 0);
    check("post_rst_total", total_value, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
